dsram_axi_bridge: RTL and testbench

//  Data-side responder for the CPU's data_sram request port (en/wen/addr/wdata -> rdata).

---
 rtl/dsram_axi_bridge_if.sv | 82 ++++++++
 rtl/dsram_axi_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_dsram_axi_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsram_axi_bridge_if.sv
// ============================================================================
// dsram_axi_bridge_if : CPU data_sram request port plus single-beat AXI3 bus
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface dsram_axi_bridge_if;
  // CPU side
  logic        flush;
  logic        req_hold;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  // AXI read address / data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AXI write address / data / response
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // The bridge is the AXI master and the responder to the CPU port.
  modport master (
    input  flush, req_hold, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output flush, req_hold, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

`default_nettype wire

// File: rtl/dsram_axi_bridge.sv
// ============================================================================
// dsram_axi_bridge : turns each CPU data_sram request into one single-beat AXI3
// read or write, stalling the pipeline until it completes.
// Optional macro DSRAM_WRITE_POST_EN : writes complete without waiting for B.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dsram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  dsram_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_D  = 3'd2,
    S_WR_AW = 3'd3,
    S_WR_B  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  logic [29:0] r_addr;
  logic [3:0]  r_wen;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_cancel;

  logic w_accept;
  logic w_busy;
  logic w_cancel;
  logic w_aw_done;
  logic w_w_done;
  logic w_unused;

`ifdef DSRAM_WRITE_POST_EN
  logic r_b_pending;
  // A posted write still owes its B response; hold off new requests until it lands.
  assign w_accept = bus.data_sram_en & ~bus.flush & ~r_b_pending;
`else
  assign w_accept = bus.data_sram_en & ~bus.flush;
`endif

  assign w_busy    = (r_state == S_RD_A) | (r_state == S_RD_D) |
                     (r_state == S_WR_AW) | (r_state == S_WR_B);
  assign w_cancel  = r_cancel | bus.flush;
  assign w_aw_done = ~r_awvalid | bus.awready;
  assign w_w_done  = ~r_wvalid | bus.wready;

  assign bus.stallreq = ((r_state == S_IDLE) & bus.data_sram_en & ~bus.flush) | w_busy;
  assign bus.data_sram_rdata = r_rdata;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = {r_addr, 2'b00};
  assign bus.arlen   = 4'd0;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = {r_addr, 2'b00};
  assign bus.awlen   = 4'd0;
  assign bus.awsize  = 3'b010;
  assign bus.awburst = 2'b01;
  assign bus.awvalid = r_awvalid;
  assign bus.wid     = AXI_ID;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = r_wen;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = r_wvalid;
  assign bus.bready  = r_bready;

  // Response IDs/status and the byte offset carry no information for this bridge.
  assign w_unused = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp, bus.data_sram_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wen     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_cancel  <= 1'b0;
`ifdef DSRAM_WRITE_POST_EN
      r_b_pending <= 1'b0;
`endif
    end else begin
`ifdef DSRAM_WRITE_POST_EN
      if (r_b_pending && bus.bvalid) begin
        r_b_pending <= 1'b0;
        r_bready    <= 1'b0;
      end
`endif
      // A flush never aborts the bus transaction; it only discards the result.
      if (w_busy && bus.flush) begin
        r_cancel <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_cancel <= 1'b0;
          if (w_accept) begin
            r_addr  <= bus.data_sram_addr[31:2];
            r_wen   <= bus.data_sram_wen;
            r_wdata <= bus.data_sram_wdata;
            if (bus.data_sram_wen == 4'b0000) begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_A;
            end else begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_AW;
            end
          end
        end

        S_RD_A: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_D;
          end
        end

        S_RD_D: begin
          if (bus.rvalid) begin
            r_rready <= 1'b0;
            if (w_cancel) begin
              r_cancel <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_rdata <= bus.rdata;
              r_state <= S_DONE;
            end
          end
        end

        S_WR_AW: begin
          // AW and W retire independently, in either order or together.
          if (bus.awready) begin
            r_awvalid <= 1'b0;
          end
          if (bus.wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
`ifdef DSRAM_WRITE_POST_EN
            r_b_pending <= 1'b1;
            r_bready    <= 1'b1;
            if (w_cancel) begin
              r_cancel <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_DONE;
            end
`else
            r_bready <= 1'b1;
            r_state  <= S_WR_B;
`endif
          end
        end

        S_WR_B: begin
          if (bus.bvalid) begin
            r_bready <= 1'b0;
            if (w_cancel) begin
              r_cancel <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // The held request has already been serviced; wait for the pipeline to move on.
          if (!bus.req_hold) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsram_axi_bridge.sv
// ============================================================================
// tb_dsram_axi_bridge : directed self-checking bench with a delay-programmable AXI slave.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dsram_axi_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dsram_axi_bridge_if bus();

  dsram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave configuration and observation
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          viol = 0, cyc = 0, ar_cyc = 0, b_cyc = 0;
  logic [31:0] last_araddr = 32'h0, last_awaddr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_wstrb = 4'h0, last_arid = 4'h0, last_wid = 4'h0;
  logic        last_wlast = 1'b0;

  initial begin : slave
    int  ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit  r_pend, b_pend, aw_got, w_got, ar_hold, aw_hold, w_hold;
    bit  ar_hs, r_hs, aw_hs, w_hs, b_hs;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rid = 4'd1; bus.rresp = 0; bus.rlast = 1;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = 4'd1; bus.bresp = 0;
    forever begin
      @(posedge clk);
      cyc++;
      ar_hs = bus.arvalid & bus.arready;
      r_hs  = bus.rvalid & bus.rready;
      aw_hs = bus.awvalid & bus.awready;
      w_hs  = bus.wvalid & bus.wready;
      b_hs  = bus.bvalid & bus.bready;
      if (rst) begin
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
      end else begin
        if ((ar_hold && !bus.arvalid) || (aw_hold && !bus.awvalid) || (w_hold && !bus.wvalid))
          viol++;
        ar_hold = bus.arvalid & ~bus.arready;
        aw_hold = bus.awvalid & ~bus.awready;
        w_hold  = bus.wvalid & ~bus.wready;
        if (r_hs) begin r_pend = 0; r_cnt++; end
        else if (r_pend) r_wait++;
        if (ar_hs) begin
          ar_cnt++; ar_cyc = cyc; last_araddr = bus.araddr; last_arid = bus.arid;
          ar_wait = 0; r_pend = 1; r_wait = 0;
        end else if (bus.arvalid) ar_wait++;
        if (b_hs) begin b_pend = 0; b_cnt++; b_cyc = cyc; end
        else if (b_pend) b_wait++;
        if (aw_hs) begin aw_cnt++; last_awaddr = bus.awaddr; aw_got = 1; aw_wait = 0; end
        else if (bus.awvalid) aw_wait++;
        if (w_hs) begin
          w_cnt++; last_wdata = bus.wdata; last_wstrb = bus.wstrb; last_wid = bus.wid;
          last_wlast = bus.wlast; w_got = 1; w_wait = 0;
        end else if (bus.wvalid) w_wait++;
        if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
      end
      #1;
      bus.arready = bus.arvalid && (ar_wait >= ar_dly);
      bus.rvalid  = r_pend && (r_wait >= r_dly);
      bus.rdata   = slave_rdata;
      bus.awready = bus.awvalid && (aw_wait >= aw_dly);
      bus.wready  = bus.wvalid && (w_wait >= w_dly);
      bus.bvalid  = b_pend && (b_wait >= b_dly);
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Presents a request and returns the number of stalled cycles (200 means it never finished).
  task automatic run_req(input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit drop, output int n);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    #1;
    n = 0;
    while (bus.stallreq === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #3;
    end
    if (drop) bus.data_sram_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    n_checks++; if (bus.stallreq !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.stallreq); else n_pass++;
    n_checks++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0)
      $display("FAIL rst_valids: got %b want 00000",
               {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready});
    else n_pass++;
    n_checks++; if (bus.data_sram_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", bus.data_sram_rdata); else n_pass++;
    rst = 1'b0;
    step;
  endtask

  task automatic test_read;
    int n;
    ar_dly = 0; r_dly = 0; slave_rdata = 32'hDEADBEEF;
    step;
    run_req(4'b0000, 32'h8000_0006, 32'h0, 1'b1, n);
    n_checks++; if (n !== 3) $display("FAIL rd_stall_cycles: got %0d want 3", n); else n_pass++;
    n_checks++; if (bus.data_sram_rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", bus.data_sram_rdata); else n_pass++;
    n_checks++; if (last_araddr !== 32'h8000_0004) $display("FAIL rd_araddr: got %h want 80000004", last_araddr); else n_pass++;
    n_checks++; if (last_arid !== 4'd1) $display("FAIL rd_arid: got %0d want 1", last_arid); else n_pass++;
    n_checks++;
    if ({bus.arlen, bus.arsize, bus.arburst} !== {4'd0, 3'b010, 2'b01})
      $display("FAIL rd_consts: got %h want %h", {bus.arlen, bus.arsize, bus.arburst}, {4'd0, 3'b010, 2'b01});
    else n_pass++;
    step;
  endtask

  task automatic test_write;
    int n, base_aw, base_w, base_b, k;
    int want_n, want_b;
    base_aw = aw_cnt; base_w = w_cnt; base_b = b_cnt;
    aw_dly = 2; w_dly = 0; b_dly = 3;
`ifdef DSRAM_WRITE_POST_EN
    want_n = 4; want_b = 0;
`else
    want_n = 8; want_b = 1;
`endif
    step;
    run_req(4'b0011, 32'h0000_2002, 32'h0000_1234, 1'b1, n);
    n_checks++; if (n !== want_n) $display("FAIL wr_stall_cycles: got %0d want %0d", n, want_n); else n_pass++;
    n_checks++; if (b_cnt - base_b !== want_b) $display("FAIL wr_b_at_done: got %0d want %0d", b_cnt - base_b, want_b); else n_pass++;
    n_checks++;
    if (aw_cnt - base_aw !== 1 || w_cnt - base_w !== 1)
      $display("FAIL wr_handshakes: got aw %0d w %0d want 1 1", aw_cnt - base_aw, w_cnt - base_w);
    else n_pass++;
    n_checks++; if (last_wstrb !== 4'b0011) $display("FAIL wr_wstrb: got %b want 0011", last_wstrb); else n_pass++;
    n_checks++;
    if ({last_awaddr, last_wdata, last_wid, last_wlast} !== {32'h0000_2000, 32'h0000_1234, 4'd1, 1'b1})
      $display("FAIL wr_fields: got %h %h %0d %b want 00002000 00001234 1 1",
               last_awaddr, last_wdata, last_wid, last_wlast);
    else n_pass++;
    k = 0;
    while (b_cnt == base_b && k < 50) begin k++; step; end
    n_checks++; if (b_cnt - base_b !== 1) $display("FAIL wr_b_total: got %0d want 1", b_cnt - base_b); else n_pass++;
    step;
  endtask

  task automatic test_flush;
    int n, k, base_ar;
    bit rr_ok;
    base_ar = ar_cnt;
    ar_dly = 0; r_dly = 5; slave_rdata = 32'h1111_2222;
    step;
    bus.data_sram_en = 1'b1; bus.data_sram_wen = 4'b0000; bus.data_sram_addr = 32'h0000_0040;
    #1;
    n_checks++; if (bus.stallreq !== 1'b1) $display("FAIL fl_accept_stall: got %b want 1", bus.stallreq); else n_pass++;
    step;
    bus.flush = 1'b1; bus.data_sram_en = 1'b0;
    #1;
    n_checks++; if (bus.stallreq !== 1'b1) $display("FAIL fl_busy_stall: got %b want 1", bus.stallreq); else n_pass++;
    step;
    bus.flush = 1'b0;
    #1;
    k = 0; rr_ok = 1'b1;
    while (bus.rvalid !== 1'b1 && k < 50) begin
      if (bus.rready !== 1'b1 || bus.stallreq !== 1'b1) rr_ok = 1'b0;
      k++;
      @(posedge clk);
      #3;
    end
    n_checks++; if (k !== 5) $display("FAIL fl_rvalid_wait: got %0d want 5", k); else n_pass++;
    n_checks++; if (!rr_ok || bus.rready !== 1'b1) $display("FAIL fl_rready_held: got %b want 1", bus.rready); else n_pass++;
    // New request presented as the cancelled read retires: it must be seen in IDLE, not DONE.
    r_dly = 0; slave_rdata = 32'h5555_AAAA;
    bus.data_sram_en = 1'b1; bus.data_sram_addr = 32'h0000_0080;
    @(posedge clk);
    #3;
    n_checks++; if (bus.stallreq !== 1'b1) $display("FAIL fl_no_done: got stall %b want 1", bus.stallreq); else n_pass++;
    n_checks++; if (bus.data_sram_rdata !== 32'hDEADBEEF) $display("FAIL fl_rdata_kept: got %h want deadbeef", bus.data_sram_rdata); else n_pass++;
    n_checks++; if (ar_cnt - base_ar !== 1) $display("FAIL fl_ar_count: got %0d want 1", ar_cnt - base_ar); else n_pass++;
    run_req(4'b0000, 32'h0000_0080, 32'h0, 1'b1, n);
    n_checks++; if (n !== 3) $display("FAIL fl_next_stall: got %0d want 3", n); else n_pass++;
    n_checks++; if (bus.data_sram_rdata !== 32'h5555_AAAA) $display("FAIL fl_next_rdata: got %h want 5555aaaa", bus.data_sram_rdata); else n_pass++;
    step;
  endtask

  task automatic test_hold;
    int n, base_ar;
    base_ar = ar_cnt;
    ar_dly = 0; r_dly = 0; slave_rdata = 32'hCAFE_F00D;
    step;
    run_req(4'b0000, 32'h0000_0100, 32'h0, 1'b0, n);
    n_checks++; if (n !== 3) $display("FAIL hold_stall: got %0d want 3", n); else n_pass++;
    bus.req_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #3;
      n_checks++;
      if (bus.stallreq !== 1'b0 || bus.data_sram_rdata !== 32'hCAFE_F00D)
        $display("FAIL hold_cycle%0d: got stall %b rdata %h want 0 cafef00d", i, bus.stallreq, bus.data_sram_rdata);
      else n_pass++;
    end
    bus.req_hold = 1'b0; bus.data_sram_en = 1'b0;
    step;
    step;
    n_checks++; if (ar_cnt - base_ar !== 1) $display("FAIL hold_ar_count: got %0d want 1", ar_cnt - base_ar); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n, base_ar, base_aw, base_b, k, want_wn, want_rn;
    base_ar = ar_cnt; base_aw = aw_cnt; base_b = b_cnt;
`ifdef DSRAM_WRITE_POST_EN
    want_wn = 5; want_rn = 6;
`else
    want_wn = 7; want_rn = 5;
`endif
    ar_dly = 1; r_dly = 2; slave_rdata = 32'hA1A1_0001;
    step;
    run_req(4'b0000, 32'h0000_1000, 32'h0, 1'b1, n);
    n_checks++; if (n !== 6) $display("FAIL b2b_rd1_stall: got %0d want 6", n); else n_pass++;
    n_checks++; if (bus.data_sram_rdata !== 32'hA1A1_0001) $display("FAIL b2b_rd1_data: got %h want a1a10001", bus.data_sram_rdata); else n_pass++;
    aw_dly = 0; w_dly = 3; b_dly = 1;
    step;
    run_req(4'b1111, 32'h0000_2004, 32'hB2B2_0002, 1'b1, n);
    n_checks++; if (n !== want_wn) $display("FAIL b2b_wr_stall: got %0d want %0d", n, want_wn); else n_pass++;
    n_checks++;
    if ({last_awaddr, last_wdata, last_wstrb} !== {32'h0000_2004, 32'hB2B2_0002, 4'b1111})
      $display("FAIL b2b_wr_fields: got %h %h %b want 00002004 b2b20002 1111", last_awaddr, last_wdata, last_wstrb);
    else n_pass++;
    ar_dly = 2; r_dly = 0; slave_rdata = 32'hC3C3_0003;
    step;
    run_req(4'b0000, 32'h0000_300B, 32'h0, 1'b1, n);
    n_checks++; if (n !== want_rn) $display("FAIL b2b_rd2_stall: got %0d want %0d", n, want_rn); else n_pass++;
    n_checks++; if (bus.data_sram_rdata !== 32'hC3C3_0003) $display("FAIL b2b_rd2_data: got %h want c3c30003", bus.data_sram_rdata); else n_pass++;
    n_checks++; if (last_araddr !== 32'h0000_3008) $display("FAIL b2b_rd2_addr: got %h want 00003008", last_araddr); else n_pass++;
    k = 0;
    while (b_cnt == base_b && k < 50) begin k++; step; end
    n_checks++;
    if (ar_cnt - base_ar !== 2 || aw_cnt - base_aw !== 1 || b_cnt - base_b !== 1)
      $display("FAIL b2b_counts: got ar %0d aw %0d b %0d want 2 1 1", ar_cnt - base_ar, aw_cnt - base_aw, b_cnt - base_b);
    else n_pass++;
    n_checks++; if (viol !== 0) $display("FAIL b2b_valid_drop: got %0d want 0", viol); else n_pass++;
    step;
  endtask

`ifdef DSRAM_WRITE_POST_EN
  task automatic test_post;
    int n, base_b;
    base_b = b_cnt;
    aw_dly = 0; w_dly = 0; b_dly = 6;
    step;
    run_req(4'b0100, 32'h0000_4000, 32'h00AB_0000, 1'b1, n);
    n_checks++; if (n !== 2) $display("FAIL post_wr_stall: got %0d want 2", n); else n_pass++;
    n_checks++; if (b_cnt !== base_b) $display("FAIL post_b_early: got %0d want %0d", b_cnt, base_b); else n_pass++;
    ar_dly = 0; r_dly = 0; slave_rdata = 32'h0F0F_0F0F;
    step;
    run_req(4'b0000, 32'h0000_5000, 32'h0, 1'b1, n);
    n_checks++; if (n !== 9) $display("FAIL post_rd_stall: got %0d want 9", n); else n_pass++;
    n_checks++; if (!(ar_cyc > b_cyc) || b_cnt - base_b !== 1) $display("FAIL post_ar_after_b: got ar %0d b %0d", ar_cyc, b_cyc); else n_pass++;
    n_checks++; if (bus.data_sram_rdata !== 32'h0F0F_0F0F) $display("FAIL post_rd_data: got %h want 0f0f0f0f", bus.data_sram_rdata); else n_pass++;
    step;
  endtask
`endif

  task automatic test_reset_mid;
    int n;
    ar_dly = 10;
    step;
    bus.data_sram_en = 1'b1; bus.data_sram_wen = 4'b0000; bus.data_sram_addr = 32'h0000_6000;
    step;
    step;
    n_checks++; if (bus.arvalid !== 1'b1) $display("FAIL rstmid_arvalid_pre: got %b want 1", bus.arvalid); else n_pass++;
    rst = 1'b1; bus.data_sram_en = 1'b0;
    step;
    #1;
    n_checks++;
    if ({bus.arvalid, bus.rready, bus.stallreq, bus.data_sram_rdata} !== {3'b000, 32'h0})
      $display("FAIL rstmid_cleared: got %b%b%b %h want 000 0", bus.arvalid, bus.rready, bus.stallreq, bus.data_sram_rdata);
    else n_pass++;
    rst = 1'b0; ar_dly = 0; r_dly = 0; slave_rdata = 32'h7777_0007;
    step;
    run_req(4'b0000, 32'h0000_7000, 32'h0, 1'b1, n);
    n_checks++;
    if (n !== 3 || bus.data_sram_rdata !== 32'h7777_0007)
      $display("FAIL rstmid_recover: got %0d %h want 3 77770007", n, bus.data_sram_rdata);
    else n_pass++;
    step;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : main
    bus.flush = 1'b0; bus.req_hold = 1'b0; bus.data_sram_en = 1'b0;
    bus.data_sram_wen = 4'b0; bus.data_sram_addr = 32'h0; bus.data_sram_wdata = 32'h0;
    test_reset;
    test_read;
    test_write;
    test_flush;
    test_hold;
    test_back_to_back;
`ifdef DSRAM_WRITE_POST_EN
    test_post;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
